// File: rtl/kl8e_tx.sv
// kl8e_tx: printer half of the KL8E console interface for the PDP-8/e core.
// Decodes printer IOTs in the F1 (skip) and F3 (action) phases, serialises
// AC[4:11] LSB first as 8N1/8N2 async on txd, keeps the printer flag and
// raises a registered interrupt request.
// Bit numbering: instruction and ac are [0:11] with bit 0 the MSB (PDP-8 order).
`timescale 1ns/1ps
module kl8e_tx #(
    parameter logic [5:0] DEV       = 6'o04,
    parameter int         CLK_FREQ  = 50000000,
    parameter int         BAUD      = 9600,
    parameter int         STOP_BITS = 1,
    parameter logic [4:0] F1_STATE  = 5'd1,
    parameter logic [4:0] F3_STATE  = 5'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [0:11] instruction,
    input  logic [4:0]  state,
    input  logic [0:11] ac,
    input  logic        UF,
    input  logic        clear,
    input  logic        kie,
    output logic        txd,
    output logic        tx_flag,
    output logic        busy,
    output logic        irq,
    output logic        mskip
);
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int STOP_LEN = STOP_BITS * DIV;
    localparam int BW       = $clog2(STOP_LEN);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DIV - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} tx_state_t;

    tx_state_t     fsm_q, fsm_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          flag_q, flag_d;
    logic          mskip_q, mskip_d;
    logic          irq_q;
    logic          frame_done;
    logic          direct_load;

    // IOT decode
    logic [2:0] op;
    logic       iot_hit, in_f1, in_f3, load;
    logic [7:0] load_data;
    logic       unused_ac;

    assign op        = instruction[9:11];
    assign iot_hit   = (instruction[0:2] == 3'b110) && (instruction[3:8] == DEV) && !UF;
    assign in_f1     = (state == F1_STATE);
    assign in_f3     = (state == F3_STATE);
    assign load      = iot_hit && in_f3 && ((op == 3'd4) || (op == 3'd6));
    assign load_data = ac[4:11];
    assign unused_ac = ^ac[0:3];

    // Frame sequencing: next FSM state, baud/bit counters, shifter and holding register.
    // A load goes straight to the shifter when the line is free (IDLE, or the last
    // stop cycle with nothing queued); otherwise it overwrites the holding register.
    always_comb begin
        fsm_d       = fsm_q;
        bcnt_d      = bcnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        frame_done  = 1'b0;
        direct_load = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                direct_load = 1'b1;
                if (load) begin
                    fsm_d   = S_START;
                    bcnt_d  = BIT_LAST;
                    shift_d = load_data;
                end
            end
            S_START: begin
                if (bcnt_q == '0) begin
                    fsm_d  = S_DATA;
                    bcnt_d = BIT_LAST;
                    bit_d  = 3'd0;
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            S_DATA: begin
                if (bcnt_q == '0) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        fsm_d  = S_STOP;
                        bcnt_d = STOP_LAST;
                    end else begin
                        bcnt_d = BIT_LAST;
                        bit_d  = bit_q + 3'd1;
                    end
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            S_STOP: begin
                if (bcnt_q == '0) begin
                    if (hold_full_q) begin
                        fsm_d       = S_START;
                        bcnt_d      = BIT_LAST;
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        direct_load = 1'b1;
                        if (load) begin
                            fsm_d   = S_START;
                            bcnt_d  = BIT_LAST;
                            shift_d = load_data;
                        end else begin
                            fsm_d      = S_IDLE;
                            frame_done = 1'b1;
                        end
                    end
                end else begin
                    bcnt_d = bcnt_q - 1'b1;
                end
            end
            default: fsm_d = S_IDLE;
        endcase
        if (load && !direct_load) begin
            hold_d      = load_data;
            hold_full_d = 1'b1;
        end
    end

    // Flag and skip: completion sets the flag last so a same-edge TCF cannot lose it.
    always_comb begin
        flag_d  = flag_q;
        mskip_d = mskip_q;
        if (iot_hit && in_f3) begin
            case (op)
                3'd0:       flag_d = 1'b1;
                3'd2, 3'd6: flag_d = 1'b0;
                default:    flag_d = flag_q;
            endcase
        end
        if (frame_done)
            flag_d = 1'b1;
        if (in_f3)
            mskip_d = 1'b0;
        else if (iot_hit && in_f1 &&
                 (((op == 3'd1) && flag_q) || ((op == 3'd5) && flag_q && kie)))
            mskip_d = 1'b1;
    end

    // State register; reset and clear abort any frame and empty the holding register.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            fsm_q       <= S_IDLE;
            bcnt_q      <= '0;
            bit_q       <= 3'd0;
            shift_q     <= 8'h00;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            flag_q      <= 1'b0;
            mskip_q     <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            bcnt_q      <= bcnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            flag_q      <= flag_d;
            mskip_q     <= mskip_d;
            irq_q       <= flag_q & kie;
        end
    end

    // Line driver: mark when idle or in stop, space for start, shifter LSB for data.
    always_comb begin
        case (fsm_q)
            S_START: txd = 1'b0;
            S_DATA:  txd = shift_q[0];
            default: txd = 1'b1;
        endcase
    end

    assign tx_flag = flag_q;
    assign busy    = (fsm_q != S_IDLE) || hold_full_q;
    assign irq     = irq_q;
    assign mskip   = mskip_q;
endmodule
